// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS core: sequences fetch, decode, execute,
// memory and writeback over the shared datapath and counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int unsigned RETIRE_CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [5:0]                  opcode,
  input  logic [5:0]                  funct,
  input  logic                        alu_zero,
  input  logic                        mem_ready,
  output logic                        pc_en,
  output logic [1:0]                  pc_src,
  output logic                        i_or_d,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic                        ir_write,
  output logic                        reg_dst,
  output logic                        mem_to_reg,
  output logic                        reg_write,
  output logic                        alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [1:0]                  alu_op,
  output logic                        illegal_instr,
  output logic [3:0]                  state,
  output logic [RETIRE_CNT_WIDTH-1:0] retire_cnt
);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  state_e                      state_q, state_d;
  logic                        illegal_q, illegal_d;
  logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;
  logic                        retire;

  // Raw enables before reset gating.
  logic pc_en_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c;

  // funct is decoded by the ALU control, not here.
  logic unused_funct;
  assign unused_funct = ^funct;

  always_comb begin
    state_d     = StFetch;
    illegal_d   = 1'b0;
    retire      = 1'b0;
    pc_en_c     = 1'b0;
    pc_src      = 2'b00;
    i_or_d      = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write_c = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;

    case (state_q)
      StFetch: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_c = mem_ready;
        pc_en_c    = mem_ready;
        state_d    = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (opcode)
          OpLw, OpSw:   state_d = StMemAddr;
          OpR:          state_d = StExecute;
          OpBeq, OpBne: state_d = StBranch;
          OpAddi:       state_d = StAddiEx;
          OpJ:          state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_read_c = 1'b1;
        i_or_d     = 1'b1;
        state_d    = mem_ready ? StMemWb : StMemRead;
      end
      StMemWb: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        retire      = 1'b1;
      end
      StMemWrite: begin
        mem_write_c = 1'b1;
        i_or_d      = 1'b1;
        retire      = mem_ready;
        state_d     = mem_ready ? StFetch : StMemWrite;
      end
      StExecute: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
        retire      = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en_c   = (opcode == OpBeq) ? alu_zero : (opcode == OpBne) ? ~alu_zero : 1'b0;
        retire    = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
      end
      StJump: begin
        pc_src  = 2'b10;
        pc_en_c = 1'b1;
        retire  = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  assign retire_cnt_d = retire ? retire_cnt_q + RETIRE_CNT_WIDTH'(1) : retire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      illegal_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      illegal_q    <= illegal_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Enables drop combinationally with reset so nothing partial commits.
  assign pc_en     = rst_n & pc_en_c;
  assign mem_read  = rst_n & mem_read_c;
  assign mem_write = rst_n & mem_write_c;
  assign ir_write  = rst_n & ir_write_c;
  assign reg_write = rst_n & reg_write_c;

  assign illegal_instr = illegal_q;
  assign state         = state_q;
  assign retire_cnt    = retire_cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction-level reference model with
// randomized opcodes, wait states and flags, plus directed reset and counter-wrap steps.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        alu_zero, mem_ready;

  logic        pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic        alu_src_a, illegal_instr;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] retire_cnt;

  logic        pc_en4, i_or_d4, mem_read4, mem_write4, ir_write4, reg_dst4, mem_to_reg4;
  logic        reg_write4, alu_src_a4, illegal_instr4;
  logic [1:0]  pc_src4, alu_src_b4, alu_op4;
  logic [3:0]  state4;
  logic [3:0]  retire_cnt4;

  int checks = 0;
  int failures = 0;
  int model_cnt = 0;
  bit pend_illegal = 1'b0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_instr(illegal_instr), .state(state),
    .retire_cnt(retire_cnt)
  );

  mips_multicycle_ctrl #(.RETIRE_CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_en(pc_en4), .pc_src(pc_src4), .i_or_d(i_or_d4),
    .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4), .reg_dst(reg_dst4),
    .mem_to_reg(mem_to_reg4), .reg_write(reg_write4), .alu_src_a(alu_src_a4),
    .alu_src_b(alu_src_b4), .alu_op(alu_op4), .illegal_instr(illegal_instr4),
    .state(state4), .retire_cnt(retire_cnt4)
  );

  always #5 clk = ~clk;

  function automatic bit rb();
    return 1'($urandom_range(1));
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {OpR, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ};
  endfunction

  // Expected control word, straight from the per-state output table.
  // {pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
  //  reg_write, alu_src_a, alu_src_b, alu_op}
  function automatic logic [14:0] exp_ctrl(input int s, input logic [5:0] op, input logic z,
                                           input logic rdy);
    logic       pe, iod, mr, mw, irw, rd, m2r, rw, sa;
    logic [1:0] ps, sb, ao;
    {pe, iod, mr, mw, irw, rd, m2r, rw, sa} = '0;
    {ps, sb, ao} = '0;
    case (s)
      0:  begin mr = 1; sb = 2'd1; irw = rdy; pe = rdy; end
      1:  sb = 2'd3;
      2:  begin sa = 1; sb = 2'd2; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin sa = 1; ao = 2'd2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 2'd1; ps = 2'd1; pe = (op == OpBne) ? ~z : z; end
      9:  begin sa = 1; sb = 2'd2; end
      10: rw = 1;
      11: begin ps = 2'd2; pe = 1; end
      default: ;
    endcase
    return {pe, ps, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao};
  endfunction

  // One clock: drive inputs after the falling edge, then check the expected state.
  task automatic cycle(input int s, input logic rdy, input logic z, input logic [5:0] op);
    logic [14:0] got, want;
    @(negedge clk);
    mem_ready = rdy;
    alu_zero  = z;
    opcode    = op;
    funct     = 6'($urandom);
    #1;
    checks++;
    assert (state === 4'(s)) else begin
      failures++; $error("FAIL state: got %0d want %0d", state, s);
    end
    checks++;
    assert (state4 === 4'(s)) else begin
      failures++; $error("FAIL state_w4: got %0d want %0d", state4, s);
    end
    got  = {pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
            reg_write, alu_src_a, alu_src_b, alu_op};
    want = exp_ctrl(s, op, z, rdy);
    checks++;
    assert (got === want) else begin
      failures++; $error("FAIL ctrl st=%0d op=%b: got %b want %b", s, op, got, want);
    end
    checks++;
    assert (illegal_instr === pend_illegal) else begin
      failures++; $error("FAIL illegal: got %b want %b", illegal_instr, pend_illegal);
    end
    checks++;
    assert (retire_cnt === 32'(model_cnt)) else begin
      failures++; $error("FAIL retire_cnt: got %0d want %0d", retire_cnt, model_cnt);
    end
    checks++;
    assert (retire_cnt4 === 4'(model_cnt)) else begin
      failures++; $error("FAIL retire_cnt_w4: got %0d want %0d", retire_cnt4, 4'(model_cnt));
    end
    pend_illegal = (s == 1) && !legal(op);
  endtask

  // Whole instruction: fw fetch wait cycles, mw memory wait cycles, z = branch zero flag.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++) cycle(0, 1'b0, rb(), op);
    cycle(0, 1'b1, rb(), op);
    cycle(1, rb(), rb(), op);
    if (!legal(op)) return;
    case (op)
      OpLw: begin
        cycle(2, rb(), rb(), op);
        for (int i = 0; i < mw; i++) cycle(3, 1'b0, rb(), op);
        cycle(3, 1'b1, rb(), op);
        cycle(4, rb(), rb(), op);
      end
      OpSw: begin
        cycle(2, rb(), rb(), op);
        for (int i = 0; i < mw; i++) cycle(5, 1'b0, rb(), op);
        cycle(5, 1'b1, rb(), op);
      end
      OpR: begin
        cycle(6, rb(), rb(), op);
        cycle(7, rb(), rb(), op);
      end
      OpBeq, OpBne: cycle(8, rb(), z, op);
      OpAddi: begin
        cycle(9, rb(), rb(), op);
        cycle(10, rb(), rb(), op);
      end
      default: cycle(11, rb(), rb(), op);
    endcase
    model_cnt++;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (state === 4'd0 && state4 === 4'd0) else begin
      failures++; $error("FAIL %s state: got %0d want 0", tag, state);
    end
    checks++;
    assert ({pc_en, ir_write, mem_read, mem_write, reg_write} === 5'b0) else begin
      failures++;
      $error("FAIL %s enables: got %b want 00000", tag,
             {pc_en, ir_write, mem_read, mem_write, reg_write});
    end
    checks++;
    assert (retire_cnt === 32'd0 && retire_cnt4 === 4'd0 && illegal_instr === 1'b0) else begin
      failures++;
      $error("FAIL %s counters: got cnt=%0d ill=%b want 0/0", tag, retire_cnt, illegal_instr);
    end
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{OpR, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ};
    rst_n = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_instr(OpLw, 0, 0, 1'b0);
    run_instr(OpLw, 0, 3, 1'b0);
    run_instr(OpBeq, 0, 0, 1'b1);
    run_instr(OpBeq, 1, 0, 1'b0);
    run_instr(OpBne, 0, 0, 1'b0);
    run_instr(OpBne, 0, 0, 1'b1);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OpR, 2, 0, 1'b0);
    for (int i = 0; i < 17; i++) run_instr(OpJ, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int k;
      k  = $urandom_range(8);
      op = (k < 7) ? ops[k] : 6'($urandom);
      run_instr(op, $urandom_range(2), $urandom_range(3), rb());
    end

    // Reset asserted while a store is waiting on memory.
    cycle(0, 1'b1, 1'b0, OpSw);
    cycle(1, 1'b0, 1'b0, OpSw);
    cycle(2, 1'b0, 1'b0, OpSw);
    cycle(5, 1'b0, 1'b0, OpSw);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_cnt    = 0;
    pend_illegal = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    run_instr(OpSw, 0, 1, 1'b0);
    run_instr(OpAddi, 0, 0, 1'b0);
    run_instr(OpLw, 1, 0, 1'b0);
    cycle(0, 1'b0, 1'b0, OpR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle, non-pipelined MIPS core.
- Sequences the shared datapath (one memory port, one ALU, register file, PC, IR) through fetch, decode, execute, memory and writeback steps.
- Decodes opcode and funct from the IR. Resolves branch PC enable from ALU zero. Stalls on a memory-ready handshake. Counts retired instructions.
- Widths come from MIPS_pkg.

Parameters:
- RETIRE_CNT_WIDTH, default MIPS_DATA_WIDTH (32): width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0]. Informational only; all R-type funct values execute.
- alu_zero  in  1  ALU zero flag during BRANCH.
- mem_ready  in  1  memory access completes this cycle.
- pc_en  out  1  PC register write enable.
- pc_src  out  2  PC mux: 00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  out  1  memory address mux: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  write register: 0 rt, 1 rd.
- mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A: 0 PC, 1 reg A.
- alu_src_b  out  2  ALU B: 00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 use funct.
- illegal_instr  out  1  one-cycle pulse on undefined opcode.
- state  out  4  current state encoding, for debug.
- retire_cnt  out  RETIRE_CNT_WIDTH  retired-instruction count.

Behaviour:
- State register, retire_cnt and illegal_instr are flops cleared asynchronously when rst_n=0. Reset state is FETCH (encoding 0).
- Control outputs are combinational from state, opcode, alu_zero and mem_ready. While rst_n=0, every enable (pc_en, ir_write, mem_read, mem_write, reg_write) is forced to 0. All unlisted outputs are 0 in every state.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, ADDI=001000, J=000010.
- States, encodings, outputs and transitions:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=pc_en=mem_ready. Go to DECODE when mem_ready=1, else hold.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode: LW/SW->MEM_ADDR, R->EXECUTE, BEQ/BNE->BRANCH, ADDI->ADDI_EX, J->JUMP.
  - DECODE with any other opcode: illegal_instr pulses high for the next cycle; go to FETCH. The instruction is not retired.
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. LW->MEM_READ, SW->MEM_WRITE.
  - MEM_READ(3): mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
  - MEM_WB(4): reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
  - MEM_WRITE(5): mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
  - EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALU_WB.
  - ALU_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. pc_en=alu_zero for BEQ, ~alu_zero for BNE. Go to FETCH.
  - ADDI_EX(9): alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
  - ADDI_WB(10): reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
  - JUMP(11): pc_src=10, pc_en=1. Go to FETCH.
  - Encodings 12-15: go to FETCH next cycle. All enables are 0 while in them.
- Memory handshake:
  - mem_read/mem_write stay asserted continuously while waiting.
  - mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.
- Cycle counts with zero-wait memory: LW 5, SW 4, R 4, ADDI 4, BEQ/BNE 3, J 3. Each cycle of mem_ready=0 adds one cycle.
- retire_cnt:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE (with mem_ready), ALU_WB, BRANCH, ADDI_WB or JUMP.
  - Wraps modulo 2^RETIRE_CNT_WIDTH.
  - Illegal or unused-state returns to FETCH do not count.
- Reset mid-operation: state goes to FETCH immediately (asynchronously) and all enables drop in the same cycle, so no partial memory or register write is committed after rst_n falls. retire_cnt returns to 0.

Test Plan:
- Reset then mem_ready=1, LW opcode 100011 -> states 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1 only in state 4. retire_cnt=1.
- LW with mem_ready low for 3 cycles in MEM_READ -> stays in state 3 for 4 cycles with mem_read=1 and i_or_d=1. Total 8 cycles. Exactly one reg_write pulse.
- BEQ with alu_zero=1, then BEQ with alu_zero=0 -> pc_en=1, pc_src=01 in state 8 for the first; pc_en=0 for the second. Both retire, retire_cnt=2.
- Opcode 111111 in DECODE -> illegal_instr high exactly one cycle, state returns to 0, retire_cnt unchanged, no write enable asserted.
- SW with mem_ready=0, rst_n pulsed low while in MEM_WRITE -> mem_write drops in the same cycle, state=0, retire_cnt=0. After release, the next fetch proceeds normally.
- RETIRE_CNT_WIDTH=4, issue 17 J instructions -> each takes 3 cycles with pc_src=10 in JUMP. retire_cnt reads 0 after the 16th and 1 after the 17th.
